branch_predictor_bht: RTL
=========================

Name: branch_predictor_bht

Overview:
Parametrised dynamic branch predictor that generalises the single-bit global prediction of the current branching unit. It holds a table of saturating counters indexed by PC, optionally XOR-hashed with a global history register (gshare mode). It is looked up in decode, and updated from execute when a conditional branch resolves. The branching unit consumes predict_taken in place of its single prediction flop; the block also provides lookup and mispredict performance counters.

Parameters:
ENTRIES, 64, number of counters; power of two, >= 4; IDX_BITS = log2(ENTRIES)
CTR_BITS, 2, width of each saturating counter, 1..4
GSHARE, 1, 0 = index from PC only; 1 = index is PC bits XOR history
HIST_BITS, 6, global history length; must be <= IDX_BITS; ignored when GSHARE=0
CNT_BITS, 32, width of the performance counters

Ports:
Clock  input  1  rising-edge clock
nReset  input  1  asynchronous active-low reset
lookup_valid  input  1  decode holds a conditional branch this cycle
lookup_pc  input  32  PC of the decode instruction (PCDEC)
predict_taken  output  1  combinational prediction, MSB of the selected counter
predict_index  output  IDX_BITS  table index used; carried down the pipe with the branch
update_valid  input  1  execute resolves a conditional branch this cycle
update_index  input  IDX_BITS  predict_index captured at lookup time
update_taken  input  1  actual branch outcome
update_mispredict  input  1  predicted direction was wrong
ghr  output  HIST_BITS  current global history, for debug
lookup_count  output  CNT_BITS  number of lookups performed
mispredict_count  output  CNT_BITS  number of mispredictions

Behaviour:
- Reset (nReset low, asynchronous):
  - every counter = 2^(CTR_BITS-1)-1 (weakly not-taken; 2'b01 at default);
  - ghr = 0; lookup_count = 0; mispredict_count = 0;
  - hence predict_taken = 0 and predict_index = lookup_pc[IDX_BITS+1:2].
- Index (combinational, independent of lookup_valid):
  - raw = lookup_pc[IDX_BITS+1:2];
  - GSHARE=1: predict_index = raw XOR {zeros, ghr}, with ghr zero-extended into the low bits;
  - GSHARE=0: predict_index = raw.
- Prediction:
  - predict_taken = MSB of counter[predict_index]; zero-cycle latency.
  - Same-cycle bypass: if update_valid and update_index == predict_index, predict_taken reflects the post-update counter value.
- Update (registered, on the edge after update_valid is sampled):
  - update_taken=1: counter increments, saturating at 2^CTR_BITS-1.
  - update_taken=0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
- History:
  - On update_valid, ghr <= {ghr[HIST_BITS-2:0], update_taken}; the history is non-speculative (resolved outcomes only).
  - With HIST_BITS=1, ghr <= update_taken.
  - With GSHARE=0, ghr still updates but does not affect the index.
- Performance counters:
  - lookup_count increments when lookup_valid is high.
  - mispredict_count increments when update_valid and update_mispredict are both high.
  - Both saturate at all-ones and never wrap.
- update_mispredict has no effect on the table; the table uses update_taken only.
- Simultaneous lookup and update of the same entry: the bypass above applies. The table write and the ghr shift both take effect on the same edge, so the next cycle's index uses the new ghr.
- Reset asserted mid-operation clears all state immediately; an in-flight update is discarded.
- Inputs are don't-care when their valid is low. update_index is trusted (no range check is needed, since the width exactly covers ENTRIES).

Test Plan:
- Reset with GSHARE=0, lookup_pc=0x0000_0040 -> predict_index=0x10, predict_taken=0, lookup_count=0, ghr=0.
- GSHARE=0: two updates of index 0x10 with taken=1 -> counter 01->10->11, predict_taken=1 after the first edge. A third taken update keeps the counter at 11 (saturation). Four not-taken updates -> counter 00, then stays at 00.
- GSHARE=1, HIST_BITS=6: updates with taken sequence 1,0,1 -> ghr=6'b000101. lookup_pc=0x0000_0040 -> predict_index = 0x10 XOR 0x05 = 0x15.
- Bypass: counter[0x10]=01, lookup and update (taken=1) both on index 0x10 in the same cycle -> predict_taken=1 in that cycle.
- Counters: 10 cycles of lookup_valid and 3 updates with mispredict=1 -> lookup_count=10, mispredict_count=3. With CNT_BITS=4, 20 lookups -> lookup_count stays at 15.
- Reset pulse asserted between an update's setup and the clock edge -> counter at reset value, ghr=0, no increment of mispredict_count.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// ============================================================================
// Module   : branch_predictor_bht
// Purpose  : Dynamic branch predictor built from a table of saturating
//            counters. The table is indexed by PC bits, optionally XOR-hashed
//            with a non-speculative global history (gshare). It is looked up
//            in decode and trained from execute when a branch resolves.
//            Lookup and mispredict performance counters are included.
// Ports    : Clock, nReset          - clock, asynchronous active-low reset
//            lookup_valid/_pc        - decode-stage branch lookup
//            predict_taken/_index    - prediction and the index used
//            update_valid/_index/_taken/_mispredict - execute-stage training
//            ghr                     - current global history (debug)
//            lookup_count, mispredict_count - saturating perf counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_bht #(
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int GSHARE    = 1,
  parameter int HIST_BITS = 6,
  parameter int CNT_BITS  = 32,
  localparam int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_pc,
  output logic                 predict_taken,
  output logic [IDX_BITS-1:0]  predict_index,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_index,
  input  logic                 update_taken,
  input  logic                 update_mispredict,
  output logic [HIST_BITS-1:0] ghr,
  output logic [CNT_BITS-1:0]  lookup_count,
  output logic [CNT_BITS-1:0]  mispredict_count
);

  // Weakly not-taken: the value just below the taken threshold.
  localparam logic [CTR_BITS-1:0] c_ctr_reset = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] c_ctr_max   = '1;
  localparam logic [CNT_BITS-1:0] c_cnt_max   = '1;

  logic [CTR_BITS-1:0]  table_q [ENTRIES];
  logic [CTR_BITS-1:0]  table_d [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [HIST_BITS-1:0] ghr_shifted;
  logic [CNT_BITS-1:0]  lookup_count_q, lookup_count_d;
  logic [CNT_BITS-1:0]  mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0]  raw_index;
  logic [CTR_BITS-1:0]  upd_ctr_cur;
  logic [CTR_BITS-1:0]  upd_ctr_next;
  logic [CTR_BITS-1:0]  sel_ctr;

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

  // Word-aligned PC: drop the byte offset bits.
  assign raw_index = lookup_pc[IDX_BITS+1:2];

  generate
    if (GSHARE != 0) begin : g_gshare
      // History is zero-extended into the low index bits before hashing.
      assign predict_index = raw_index ^ IDX_BITS'(ghr_q);
    end else begin : g_pc_only
      assign predict_index = raw_index;
    end
  endgenerate

  generate
    if (HIST_BITS == 1) begin : g_hist_single
      assign ghr_shifted = update_taken;
    end else begin : g_hist_shift
      assign ghr_shifted = {ghr_q[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  // Saturating next value of the entry being trained.
  always_comb begin
    upd_ctr_cur  = table_q[update_index];
    upd_ctr_next = upd_ctr_cur;
    if (update_taken) begin
      if (upd_ctr_cur != c_ctr_max) upd_ctr_next = upd_ctr_cur + CTR_BITS'(1);
    end else begin
      if (upd_ctr_cur != '0) upd_ctr_next = upd_ctr_cur - CTR_BITS'(1);
    end
  end

  // Bypass: a same-cycle update of the looked-up entry is visible immediately.
  always_comb begin
    if (update_valid && (update_index == predict_index)) sel_ctr = upd_ctr_next;
    else                                                 sel_ctr = table_q[predict_index];
  end

  assign predict_taken = sel_ctr[CTR_BITS-1];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) table_d[i] = table_q[i];
    if (update_valid) table_d[update_index] = upd_ctr_next;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (update_valid) ghr_d = ghr_shifted;
  end

  always_comb begin
    lookup_count_d = lookup_count_q;
    if (lookup_valid && (lookup_count_q != c_cnt_max))
      lookup_count_d = lookup_count_q + CNT_BITS'(1);
  end

  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (update_valid && update_mispredict && (mispredict_count_q != c_cnt_max))
      mispredict_count_d = mispredict_count_q + CNT_BITS'(1);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= c_ctr_reset;
      ghr_q              <= '0;
      lookup_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= table_d[i];
      ghr_q              <= ghr_d;
      lookup_count_q     <= lookup_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign ghr              = ghr_q;
  assign lookup_count     = lookup_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

`default_nettype wire
